vga_plot_sink: RTL



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_timing_gen.sv | 62 ++++++
 rtl/vga_plot_sink.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg - framebuffer geometry and 640x480@60 timing constants           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vga_pkg;

  localparam int FB_DEPTH = 19200;
  localparam int FB_AW    = 15;
  localparam int COLOUR_W = 3;
  localparam int HC_W     = 10;
  localparam int VC_W     = 10;

  localparam logic [7:0]       FB_W    = 8'd160;
  localparam logic [6:0]       FB_H    = 7'd120;
  localparam logic [FB_AW-1:0] FB_LAST = 15'd19199;

  localparam logic [HC_W-1:0] H_VIS   = 10'd640;
  localparam logic [HC_W-1:0] H_FP    = 10'd16;
  localparam logic [HC_W-1:0] H_SYNC  = 10'd96;
  localparam logic [HC_W-1:0] H_TOTAL = 10'd800;
  localparam logic [HC_W-1:0] H_LAST  = H_TOTAL - 10'd1;
  localparam logic [HC_W-1:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [HC_W-1:0] H_SYNC_END   = H_VIS + H_FP + H_SYNC;

  localparam logic [VC_W-1:0] V_VIS   = 10'd480;
  localparam logic [VC_W-1:0] V_FP    = 10'd10;
  localparam logic [VC_W-1:0] V_SYNC  = 10'd2;
  localparam logic [VC_W-1:0] V_TOTAL = 10'd525;
  localparam logic [VC_W-1:0] V_LAST  = V_TOTAL - 10'd1;
  localparam logic [VC_W-1:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [VC_W-1:0] V_SYNC_END   = V_VIS + V_FP + V_SYNC;

  typedef logic [FB_AW-1:0]    fb_addr_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_e;

  // row*160 + col using shifts only: (row<<7) + (row<<5) + col
  function automatic fb_addr_t fb_addr(input logic [7:0] row, input logic [7:0] col);
    fb_addr_t r15;
    fb_addr_t c15;
    r15 = {7'd0, row};
    c15 = {7'd0, col};
    return (r15 << 7) + (r15 << 5) + c15;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen - 25 MHz pixel enable, h/v counters, sync/visible decode  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       visible,
  output logic [7:0] fb_col,
  output logic [7:0] fb_row
);

  logic            pix_en_q, pix_en_d;
  logic [HC_W-1:0] h_cnt_q, h_cnt_d;
  logic [VC_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  always_comb begin
    hsync_n = ~((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
    vsync_n = ~((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
    visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    // 4x4 replication: each framebuffer cell covers four counts in h and v
    fb_col  = h_cnt_q[HC_W-1:2];
    fb_row  = v_cnt_q[VC_W-1:2];
  end

endmodule
`default_nettype wire

// File: rtl/vga_plot_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_plot_sink - plot-port framebuffer with clear FSM and VGA scanout     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_plot_sink
  import vga_pkg::*;
#(
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       plot_drop,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [2:0] vga_rgb
);

  ctrl_state_e state_q;
  fb_addr_t    clr_addr_q;
  logic        busy_q;
  logic        plot_drop_q;

  logic        plot_in_range;
  fb_addr_t    plot_addr;

  assign plot_in_range = (x < FB_W) && (y < FB_H);
  assign plot_addr     = fb_addr({1'b0, y}, x);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      busy_q      <= CLEAR_ON_RESET;
      clr_addr_q  <= '0;
      plot_drop_q <= 1'b0;
    end else begin
      plot_drop_q <= plot && ((state_q == ST_CLEAR) || !plot_in_range);
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == FB_LAST) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b0;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 15'd1;
          end
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign plot_drop = plot_drop_q;

  logic     wr_en;
  fb_addr_t wr_addr;
  colour_t  wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_data = colour;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr_q;
        wr_data = BG_COLOUR;
      end else if (plot && plot_in_range) begin
        wr_en = 1'b1;
      end
    end
  end

  logic       tg_hsync_n;
  logic       tg_vsync_n;
  logic       tg_visible;
  logic [7:0] tg_col;
  logic [7:0] tg_row;

  vga_timing_gen u_timing (
    .clock   (clock),
    .reset   (reset),
    .hsync_n (tg_hsync_n),
    .vsync_n (tg_vsync_n),
    .visible (tg_visible),
    .fb_col  (tg_col),
    .fb_row  (tg_row)
  );

  // Blanking rows/columns would index past the buffer, so park them on 0
  fb_addr_t rd_addr;
  assign rd_addr = tg_visible ? fb_addr(tg_row, tg_col) : '0;

  colour_t fb_mem [FB_DEPTH];
  colour_t rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= wr_data;
    end
    rd_data_q <= fb_mem[rd_addr];
  end

  logic    s1_hs_q, s1_hs_d;
  logic    s1_vs_q, s1_vs_d;
  logic    s1_vis_q, s1_vis_d;
  logic    out_hs_q, out_hs_d;
  logic    out_vs_q, out_vs_d;
  logic    out_vis_q, out_vis_d;
  colour_t out_rgb_q, out_rgb_d;

  // Stage 1 runs alongside the RAM read; stage 2 merges sync/blank with data
  always_comb begin
    s1_hs_d   = tg_hsync_n;
    s1_vs_d   = tg_vsync_n;
    s1_vis_d  = tg_visible;
    out_hs_d  = s1_hs_q;
    out_vs_d  = s1_vs_q;
    out_vis_d = s1_vis_q;
    out_rgb_d = s1_vis_q ? rd_data_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      s1_vis_q  <= 1'b0;
      out_hs_q  <= 1'b1;
      out_vs_q  <= 1'b1;
      out_vis_q <= 1'b0;
      out_rgb_q <= '0;
    end else begin
      s1_hs_q   <= s1_hs_d;
      s1_vs_q   <= s1_vs_d;
      s1_vis_q  <= s1_vis_d;
      out_hs_q  <= out_hs_d;
      out_vs_q  <= out_vs_d;
      out_vis_q <= out_vis_d;
      out_rgb_q <= out_rgb_d;
    end
  end

  assign vga_hs      = out_hs_q;
  assign vga_vs      = out_vs_q;
  assign vga_blank_n = out_vis_q;
  assign vga_rgb     = out_rgb_q;

endmodule
`default_nettype wire
